// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle MULT/DIV unit with HI/LO results and pipeline stall.
//            Define MULDIV_SIGNED_EN for two's complement operands.
//            Leave it undefined for unsigned operands.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            c_CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_PREP = 3'd1;
  localparam logic [2:0] c_RUN  = 3'd2;
  localparam logic [2:0] c_FIX  = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_nstate;
  logic             w_accept;

  logic             r_op;
  logic [WIDTH-1:0] r_rs;
  logic [WIDTH-1:0] r_rt;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [c_CW-1:0]  r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_rt_zero;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_dshift;
  logic [WIDTH:0]   w_ddiff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_accept  = start && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_rt_zero = (r_rt == '0);

`ifdef MULDIV_SIGNED_EN
  assign w_neg_a = r_rs[WIDTH-1];
  assign w_neg_b = r_rt[WIDTH-1];
  assign w_mag_a = w_neg_a ? -r_rs : r_rs;
  assign w_mag_b = w_neg_b ? -r_rt : r_rt;
`else
  assign w_neg_a = 1'b0;
  assign w_neg_b = 1'b0;
  assign w_mag_a = r_rs;
  assign w_mag_b = r_rt;
`endif

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set.
  assign w_madd   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  // Divide: bit WIDTH of the difference is the borrow (partial remainder < divisor).
  assign w_dshift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_b};
  assign w_prod   = {r_acc_hi, r_acc_lo};

  always_comb begin
    w_fix_hi = r_acc_hi;
    w_fix_lo = r_acc_lo;
    if (r_dbz) begin
      w_fix_hi = r_rs;
      w_fix_lo = '1;
    end else if (!r_op) begin
      {w_fix_hi, w_fix_lo} = r_neg_q ? -w_prod : w_prod;
    end else begin
      w_fix_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
      w_fix_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      c_IDLE:  w_nstate = w_accept ? c_PREP : c_IDLE;
      c_PREP:  w_nstate = (r_op && w_rt_zero) ? c_FIX : c_RUN;
      c_RUN:   w_nstate = (r_cnt == c_LAST) ? c_FIX : c_RUN;
      c_FIX:   w_nstate = c_DONE;
      c_DONE:  w_nstate = w_accept ? c_PREP : c_IDLE;
      default: w_nstate = c_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (r_state)
      c_PREP, c_RUN, c_FIX: busy = 1'b1;
      c_DONE: begin
        done        = 1'b1;
        div_by_zero = r_dbz;
      end
      default: ;
    endcase
    stall = busy | w_accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= 1'b0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_op <= op;
        r_rs <= rs_data;
        r_rt <= rt_data;
      end
      case (r_state)
        c_PREP: begin
          r_b      <= r_op ? w_mag_b : w_mag_a;
          r_acc_lo <= r_op ? w_mag_a : w_mag_b;
          r_acc_hi <= '0;
          r_cnt    <= '0;
          r_neg_q  <= w_neg_a ^ w_neg_b;
          r_neg_r  <= w_neg_a;
          r_dbz    <= r_op && w_rt_zero;
        end
        c_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_op) begin
            r_acc_hi <= w_madd[WIDTH:1];
            r_acc_lo <= {w_madd[0], r_acc_lo[WIDTH-1:1]};
          end else if (!w_ddiff[WIDTH]) begin
            r_acc_hi <= w_ddiff[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_acc_hi <= w_dshift[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
          end
        end
        c_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Randomized and directed self-checking bench for muldiv_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         busy;
  logic         stall;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition of MULT/DIV.
  task automatic ref_model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] eh, output logic [W-1:0] el,
                           output logic ed);
    logic [63:0] p;
    ed = 1'b0;
    if (o && (b == '0)) begin
      eh = a;
      el = '1;
      ed = 1'b1;
    end else begin
`ifdef MULDIV_SIGNED_EN
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!o) begin
        p  = 64'(sa * sb);
        eh = p[63:32];
        el = p[31:0];
      end else begin
        q  = sa / sb;
        r  = sa % sb;
        el = W'(q);
        eh = W'(r);
      end
`else
      if (!o) begin
        p  = {32'b0, a} * {32'b0, b};
        eh = p[63:32];
        el = p[31:0];
      end else begin
        el = a / b;
        eh = a % b;
      end
`endif
    end
  endtask

  // Issue one operation; hold start for 'hold' edges after acceptance with junk operands.
  task automatic do_op(input string tag, input logic o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold, input bit chk_idle);
    logic [W-1:0] eh, el;
    logic         ed;
    int           edges, busy_cnt, stall_bad, exp_edges;
    ref_model(o, a, b, eh, el, ed);
    exp_edges = ed ? 3 : W + 3;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    #1 check({tag, "_stall_issue"}, {63'b0, stall}, 64'd1);
    @(posedge clk);
    edges = 1; busy_cnt = 0; stall_bad = 0;
    #1;
    while (!done && edges < 200) begin
      if (edges < hold) begin
        start = 1'b1; op = 1'($urandom); rs_data = $urandom; rt_data = $urandom;
      end else begin
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
      end
      if (busy) busy_cnt++;
      if (busy && !stall) stall_bad++;
      @(posedge clk);
      #1 edges++;
    end
    start = 1'b0;
    check({tag, "_done"}, {63'b0, done}, 64'd1);
    check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_edges - 1));
    check({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
    check({tag, "_hi"}, {32'b0, hi}, {32'b0, eh});
    check({tag, "_lo"}, {32'b0, lo}, {32'b0, el});
    check({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, ed});
    if (chk_idle) begin
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {62'b0, done, busy}, 64'd0);
      check({tag, "_hold"}, {hi, lo}, {eh, el});
      check({tag, "_stall_idle"}, {63'b0, stall}, 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         o;
    int           sel;
    reset = 1'b0; start = 1'b0; op = 1'b0; rs_data = '0; rt_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {58'b0, busy, done, div_by_zero, stall, 2'b0}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;

    do_op("mult_7x6",    1'b0, 32'd7,        32'd6,        0, 1'b1);
    do_op("mult_neg1x2", 1'b0, 32'hFFFFFFFF, 32'h00000002, 0, 1'b1);
    do_op("div_m7_2",    1'b1, 32'hFFFFFFF9, 32'h00000002, 0, 1'b1);
    do_op("div_100_7",   1'b1, 32'd100,      32'd7,        0, 1'b1);
    do_op("div_by_zero", 1'b1, 32'd5,        32'd0,        0, 1'b1);
    do_op("div_min_m1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1);
    do_op("hold_start",  1'b0, 32'h12345678, 32'h9ABCDEF1, 20, 1'b1);

    // Reset in the middle of RUN must clear state and results immediately.
    @(negedge clk);
    start = 1'b1; op = 1'b0; rs_data = 32'h0BADF00D; rt_data = 32'h00001234;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("midrun_busy_pre", {63'b0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("midrun_rst_flags", {61'b0, busy, done, div_by_zero}, 64'd0);
    check("midrun_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op("post_rst_3x3", 1'b0, 32'd3, 32'd3, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      o   = 1'($urandom);
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = '0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = 32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      do_op("rand", o, a, b, 0, ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, operand/HI/LO width in bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL provide port: clk  input  1  rising-edge clock.
REQ-004 SHALL provide port: reset  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port: start  input  1  request from decode for MULT/DIV issue.
REQ-006 SHALL provide port: op  input  1  operation select, 0=MULT, 1=DIV.
REQ-007 SHALL provide port: rs_data  input  WIDTH  multiplicand or dividend.
REQ-008 SHALL provide port: rt_data  input  WIDTH  multiplier or divisor.
REQ-009 SHALL provide port: busy  output  1  operation in flight.
REQ-010 SHALL provide port: stall  output  1  PC/pipeline hold request to the processor.
REQ-011 SHALL provide port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL provide port: div_by_zero  output  1  one-cycle flag, coincident with done.
REQ-013 SHALL provide port: hi  output  WIDTH  HI register (product upper half / remainder).
REQ-014 SHALL provide port: lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-015 SHALL implement FSM states IDLE, PREP, RUN, FIX, DONE.
REQ-016 SHALL sample start in IDLE or DONE only; on acceptance, latch op/rs_data/rt_data and go to PREP.
REQ-017 SHALL ignore start in PREP, RUN and FIX; latched operands SHALL not change.
REQ-018 PREP SHALL compute operand magnitudes and result signs; clear 5-bit iteration counter; go to RUN.
REQ-019 PREP with op=DIV and rt_data==0 SHALL skip RUN and go directly to FIX.
REQ-020 RUN SHALL execute one shift-add (MULT) or restoring shift-subtract (DIV) step per cycle, WIDTH steps exactly, then go to FIX.
REQ-021 FIX SHALL apply sign correction, write hi/lo on the FIX->DONE edge, and go to DONE.
REQ-022 DONE SHALL last one cycle and then return to IDLE, unless start is accepted (-> PREP).
REQ-023 done SHALL be high only in DONE; done SHALL rise WIDTH+3 edges after start is sampled (3 edges for divide-by-zero).
REQ-024 busy SHALL be high in PREP, RUN and FIX (WIDTH+2 cycles normal, 2 cycles divide-by-zero).
REQ-025 stall SHALL equal busy OR (start AND state in {IDLE, DONE}), combinationally, so the issuing cycle is held.
REQ-026 MULT SHALL produce {hi,lo} = full 2*WIDTH-bit product.
REQ-027 DIV SHALL produce lo=quotient, hi=remainder; remainder sign SHALL follow dividend.
REQ-028 Divide-by-zero SHALL give lo=all ones, hi=rs_data, div_by_zero=1 for the DONE cycle.
REQ-029 hi/lo SHALL hold their values at all times except the FIX->DONE edge.

Reset
REQ-030 reset low SHALL immediately force state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, div_by_zero=0, at any point including mid-RUN.
REQ-031 After reset deassertion, first accepted start SHALL behave identically to a cold-start operation.

Configuration
REQ-032 Macro MULDIV_SIGNED_EN defined: operands SHALL be two's complement (MIPS MULT/DIV); magnitude conversion in PREP, sign fix in FIX; DIV of most-negative by -1 SHALL give lo=most-negative, hi=0.
REQ-033 MULDIV_SIGNED_EN undefined: operands SHALL be unsigned (MULTU/DIVU semantics); PREP and FIX SHALL perform no sign handling; latency SHALL be unchanged.

Verification (WIDTH=32)
REQ-034 MULT 7 x 6 -> busy high 34 cycles, done at edge 35, hi=00000000, lo=0000002A.
REQ-035 MULT FFFFFFFF x 00000002 -> signed build hi=FFFFFFFF, lo=FFFFFFFE; unsigned build hi=00000001, lo=FFFFFFFE.
REQ-036 DIV FFFFFFF9 / 00000002 (signed build) -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 00000064 / 00000007 -> lo=0000000E, hi=00000002.
REQ-037 DIV 00000005 / 00000000 -> done and div_by_zero at edge 3, lo=FFFFFFFF, hi=00000005.
REQ-038 start held high during busy -> no restart, result unchanged; reset pulsed low at RUN cycle 10 -> busy=0, hi=lo=0 immediately, next MULT 3 x 3 -> lo=00000009.
